// File: rtl/hazard_unit.sv
// hazard_unit: operand forwarding, load-use / branch stall-flush control and I/D refill sequencing.
// Optional saturating performance counters are compiled in with `define HAZARD_PERF_CNT_EN.
module hazard_unit (
  input  logic        i_clk,
  input  logic        i_arst,
  input  logic [4:0]  i_rs1_addr_dec,
  input  logic [4:0]  i_rs2_addr_dec,
  input  logic [4:0]  i_rs1_addr_exec,
  input  logic [4:0]  i_rs2_addr_exec,
  input  logic [4:0]  i_rd_addr_exec,
  input  logic [4:0]  i_rd_addr_mem,
  input  logic [4:0]  i_rd_addr_wb,
  input  logic        i_reg_we_mem,
  input  logic        i_reg_we_wb,
  input  logic        i_pc_src_exec,
  input  logic        i_load_instr_exec,
  input  logic        i_icache_miss,
  input  logic        i_dcache_miss,
  input  logic        i_mem_ack,
  output logic        o_mem_req,
  output logic        o_mem_sel,
  output logic        o_stall_fetch,
  output logic        o_stall_dec,
  output logic        o_stall_back,
  output logic        o_flush_dec,
  output logic        o_flush_exec,
  output logic [1:0]  o_forward_rs1,
  output logic [1:0]  o_forward_rs2,
  output logic [31:0] o_stall_cycles,
  output logic [31:0] o_flush_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    D_WAIT = 2'd1,
    I_WAIT = 2'd2
  } state_t;

  state_t     state_r;
  logic       mem_req_r;
  logic       mem_sel_r;
  logic       idle_s;
  logic       load_use_s;
  logic       stall_fetch_s;
  logic       stall_dec_s;
  logic       stall_back_s;
  logic       flush_dec_s;
  logic       flush_exec_s;
  logic [1:0] fwd_rs1_s;
  logic [1:0] fwd_rs2_s;

  // The MEM-stage result is younger than WB, so it wins when both match.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       we_mem,
    input logic [4:0] rd_mem,
    input logic       we_wb,
    input logic [4:0] rd_wb
  );
    logic [1:0] sel;
    if (we_mem && (rd_mem != 5'd0) && (rd_mem == rs)) begin
      sel = 2'b10;
    end else if (we_wb && (rd_wb != 5'd0) && (rd_wb == rs)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Operand source selection for both execute-stage sources
  always_comb begin
    fwd_rs1_s = fwd_sel(i_rs1_addr_exec, i_reg_we_mem, i_rd_addr_mem, i_reg_we_wb, i_rd_addr_wb);
    fwd_rs2_s = fwd_sel(i_rs2_addr_exec, i_reg_we_mem, i_rd_addr_mem, i_reg_we_wb, i_rd_addr_wb);
  end

  // Load in execute whose destination is read by the instruction in decode
  always_comb begin
    if (i_load_instr_exec && (i_rd_addr_exec != 5'd0) &&
        ((i_rd_addr_exec == i_rs1_addr_dec) || (i_rd_addr_exec == i_rs2_addr_dec))) begin
      load_use_s = 1'b1;
    end else begin
      load_use_s = 1'b0;
    end
  end

  assign idle_s = (state_r == IDLE);

  // Stall/flush arbitration: refill freezes everything, then branch beats load-use
  always_comb begin
    stall_fetch_s = 1'b0;
    stall_dec_s   = 1'b0;
    stall_back_s  = 1'b0;
    flush_dec_s   = 1'b0;
    flush_exec_s  = 1'b0;
    if (!idle_s) begin
      stall_fetch_s = 1'b1;
      stall_dec_s   = 1'b1;
      stall_back_s  = 1'b1;
    end else if (i_pc_src_exec) begin
      flush_dec_s  = 1'b1;
      flush_exec_s = 1'b1;
    end else if (load_use_s) begin
      stall_fetch_s = 1'b1;
      stall_dec_s   = 1'b1;
      flush_exec_s  = 1'b1;
    end else begin
      stall_fetch_s = 1'b0;
    end
  end

  // Refill sequencer; the target is captured on entry and held until ack
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_r   <= IDLE;
      mem_req_r <= 1'b0;
      mem_sel_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (i_dcache_miss) begin
            state_r   <= D_WAIT;
            mem_req_r <= 1'b1;
            mem_sel_r <= 1'b1;
          end else if (i_icache_miss) begin
            state_r   <= I_WAIT;
            mem_req_r <= 1'b1;
            mem_sel_r <= 1'b0;
          end else begin
            state_r   <= IDLE;
            mem_req_r <= 1'b0;
            mem_sel_r <= 1'b0;
          end
        end
        D_WAIT, I_WAIT: begin
          if (i_mem_ack) begin
            state_r   <= IDLE;
            mem_req_r <= 1'b0;
            mem_sel_r <= 1'b0;
          end else begin
            state_r   <= state_r;
            mem_req_r <= 1'b1;
            mem_sel_r <= mem_sel_r;
          end
        end
        default: begin
          state_r   <= IDLE;
          mem_req_r <= 1'b0;
          mem_sel_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] flush_cnt_r;

  // Saturating event counters for stalled fetch cycles and decode flushes
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      stall_cnt_r <= 32'd0;
      flush_cnt_r <= 32'd0;
    end else begin
      if (stall_fetch_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_dec_s && (flush_cnt_r != 32'hFFFF_FFFF)) begin
        flush_cnt_r <= flush_cnt_r + 32'd1;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign o_stall_cycles = stall_cnt_r;
  assign o_flush_count  = flush_cnt_r;
`else
  assign o_stall_cycles = 32'd0;
  assign o_flush_count  = 32'd0;
`endif

  assign o_mem_req     = mem_req_r;
  assign o_mem_sel     = mem_sel_r;
  assign o_stall_fetch = stall_fetch_s;
  assign o_stall_dec   = stall_dec_s;
  assign o_stall_back  = stall_back_s;
  assign o_flush_dec   = flush_dec_s;
  assign o_flush_exec  = flush_exec_s;
  assign o_forward_rs1 = fwd_rs1_s;
  assign o_forward_rs2 = fwd_rs2_s;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized traffic
// compared against a rule-level reference model of the pipeline controller.
module tb_hazard_unit;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        arst;
  logic [4:0]  rs1_dec, rs2_dec, rs1_exec, rs2_exec, rd_exec, rd_mem, rd_wb;
  logic        we_mem, we_wb, pc_src, load_exec, imiss, dmiss, ack;
  logic        mem_req, mem_sel, stall_fetch, stall_dec, stall_back, flush_dec, flush_exec;
  logic [1:0]  fwd1, fwd2;
  logic [31:0] stall_cycles, flush_count;

  int          checks = 0;
  int          errors = 0;

  // reference model: refill in progress + its target, and event counts
  bit          m_busy;
  bit          m_data;
  logic [31:0] m_stall;
  logic [31:0] m_flush;

  logic [10:0] obs_vec;
  logic [10:0] exp_vec;

  hazard_unit dut (
    .i_clk(clk), .i_arst(arst),
    .i_rs1_addr_dec(rs1_dec), .i_rs2_addr_dec(rs2_dec),
    .i_rs1_addr_exec(rs1_exec), .i_rs2_addr_exec(rs2_exec),
    .i_rd_addr_exec(rd_exec), .i_rd_addr_mem(rd_mem), .i_rd_addr_wb(rd_wb),
    .i_reg_we_mem(we_mem), .i_reg_we_wb(we_wb),
    .i_pc_src_exec(pc_src), .i_load_instr_exec(load_exec),
    .i_icache_miss(imiss), .i_dcache_miss(dmiss), .i_mem_ack(ack),
    .o_mem_req(mem_req), .o_mem_sel(mem_sel),
    .o_stall_fetch(stall_fetch), .o_stall_dec(stall_dec), .o_stall_back(stall_back),
    .o_flush_dec(flush_dec), .o_flush_exec(flush_exec),
    .o_forward_rs1(fwd1), .o_forward_rs2(fwd2),
    .o_stall_cycles(stall_cycles), .o_flush_count(flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs_vec = {fwd1, fwd2, stall_fetch, stall_dec, stall_back, flush_dec, flush_exec, mem_req, mem_sel};

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
    if (we_mem && rd_mem != 5'd0 && rd_mem == rs) return 2'b10;
    if (we_wb && rd_wb != 5'd0 && rd_wb == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [10:0] expect_vec();
    bit lu, idle, sf, fd, fe;
    lu   = load_exec && rd_exec != 5'd0 && (rd_exec == rs1_dec || rd_exec == rs2_dec);
    idle = !m_busy;
    sf   = !idle || (!pc_src && lu);
    fd   = idle && pc_src;
    fe   = idle && (pc_src || lu);
    return {fwd_ref(rs1_exec), fwd_ref(rs2_exec), sf, sf, !idle, fd, fe, m_busy, m_busy && m_data};
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_data = 1'b0; m_stall = 32'd0; m_flush = 32'd0;
  endtask

  // advance the model by one clock edge using the inputs currently applied
  task automatic model_clock();
    logic [10:0] e;
    e = expect_vec();
    if (PERF && e[6] && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
    if (PERF && e[3] && m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 32'd1;
    if (!m_busy) begin
      if (dmiss) begin m_busy = 1'b1; m_data = 1'b1; end
      else if (imiss) begin m_busy = 1'b1; m_data = 1'b0; end
    end else if (ack) begin
      m_busy = 1'b0;
    end
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    rs1_dec = 5'd0; rs2_dec = 5'd0; rs1_exec = 5'd0; rs2_exec = 5'd0;
    rd_exec = 5'd0; rd_mem = 5'd0; rd_wb = 5'd0;
    we_mem = 1'b0; we_wb = 1'b0; pc_src = 1'b0; load_exec = 1'b0;
    imiss = 1'b0; dmiss = 1'b0; ack = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    arst = 1'b1;
    model_reset();
    #2;
    checks++;
    if (obs_vec !== 11'd0 || stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: got vec=%b cnt=%h/%h, want all zero", obs_vec, stall_cycles, flush_count);
    end
    @(negedge clk);
    arst = 1'b0;
    #1;
    checks++;
    if (obs_vec !== 11'd0) begin
      errors++;
      $display("FAIL idle_after_reset: got vec=%b, want 0", obs_vec);
    end
  endtask

  task automatic test_forwarding();
    clear_inputs();
    rd_mem = 5'd5; rd_wb = 5'd5; we_mem = 1'b1; we_wb = 1'b1; rs1_exec = 5'd5; rs2_exec = 5'd9;
    #1;
    checks++;
    if (fwd1 !== 2'b10 || fwd2 !== 2'b00) begin
      errors++;
      $display("FAIL fwd_mem_priority: got rs1=%b rs2=%b, want 10 00", fwd1, fwd2);
    end
    we_mem = 1'b0;
    #1;
    checks++;
    if (fwd1 !== 2'b01) begin
      errors++;
      $display("FAIL fwd_wb: got %b, want 01", fwd1);
    end
    we_mem = 1'b1; rd_mem = 5'd0; rd_wb = 5'd0; rs1_exec = 5'd0; rs2_exec = 5'd0;
    #1;
    checks++;
    if (fwd1 !== 2'b00 || fwd2 !== 2'b00) begin
      errors++;
      $display("FAIL fwd_rd_zero: got rs1=%b rs2=%b, want 00 00", fwd1, fwd2);
    end
    rd_mem = 5'd12; rd_wb = 5'd12; rs2_exec = 5'd12; we_mem = 1'b0;
    #1;
    exp_vec = expect_vec();
    checks++;
    if (obs_vec !== exp_vec) begin
      errors++;
      $display("FAIL fwd_rs2_wb: got %b, want %b", obs_vec, exp_vec);
    end
    tick();
  endtask

  task automatic test_load_use();
    clear_inputs();
    load_exec = 1'b1; rd_exec = 5'd7; rs1_dec = 5'd3; rs2_dec = 5'd7;
    #1;
    checks++;
    if ({stall_fetch, stall_dec, flush_exec, flush_dec, stall_back} !== 5'b11100) begin
      errors++;
      $display("FAIL load_use: got sf/sd/fe/fd/sb=%b, want 11100", {stall_fetch, stall_dec, flush_exec, flush_dec, stall_back});
    end
    tick();
    load_exec = 1'b0;
    #1;
    checks++;
    if ({stall_fetch, stall_dec, flush_exec} !== 3'b000) begin
      errors++;
      $display("FAIL load_use_release: got %b, want 000", {stall_fetch, stall_dec, flush_exec});
    end
    load_exec = 1'b1; rd_exec = 5'd0; rs1_dec = 5'd0;
    #1;
    checks++;
    if (stall_fetch !== 1'b0) begin
      errors++;
      $display("FAIL load_use_rd0: got stall_fetch=%b, want 0", stall_fetch);
    end
    tick();
  endtask

  task automatic test_branch_vs_load();
    clear_inputs();
    load_exec = 1'b1; rd_exec = 5'd7; rs2_dec = 5'd7; pc_src = 1'b1;
    #1;
    checks++;
    if ({flush_dec, flush_exec, stall_fetch, stall_dec} !== 4'b1100) begin
      errors++;
      $display("FAIL branch_over_load: got fd/fe/sf/sd=%b, want 1100", {flush_dec, flush_exec, stall_fetch, stall_dec});
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_miss();
    clear_inputs();
    dmiss = 1'b1; imiss = 1'b1; ack = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || stall_back !== 1'b0) begin
      errors++;
      $display("FAIL miss_not_yet: got req=%b sb=%b, want 0 0", mem_req, stall_back);
    end
    tick();
    ack = 1'b0; pc_src = 1'b1;
    #1;
    checks++;
    if ({mem_req, mem_sel, stall_back, stall_fetch, flush_dec} !== 5'b11110) begin
      errors++;
      $display("FAIL dual_miss_data_first: got req/sel/sb/sf/fd=%b, want 11110", {mem_req, mem_sel, stall_back, stall_fetch, flush_dec});
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      dmiss = 1'b0;
      #1;
      checks++;
      if ({mem_req, mem_sel, stall_back} !== 3'b111) begin
        errors++;
        $display("FAIL d_wait_hold%0d: got req/sel/sb=%b, want 111", k, {mem_req, mem_sel, stall_back});
      end
    end
    pc_src = 1'b0; ack = 1'b1;
    tick();
    ack = 1'b0;
    #1;
    checks++;
    if ({mem_req, stall_back} !== 2'b00) begin
      errors++;
      $display("FAIL ack_to_idle: got req/sb=%b, want 00", {mem_req, stall_back});
    end
    tick();
    #1;
    checks++;
    if ({mem_req, mem_sel, stall_back} !== 3'b101) begin
      errors++;
      $display("FAIL i_wait: got req/sel/sb=%b, want 101", {mem_req, mem_sel, stall_back});
    end
    imiss = 1'b0; ack = 1'b1;
    tick();
    ack = 1'b0;
    #1;
    exp_vec = expect_vec();
    checks++;
    if (obs_vec !== exp_vec || stall_cycles !== m_stall || flush_count !== m_flush) begin
      errors++;
      $display("FAIL miss_end: got %b cnt=%0d/%0d, want %b cnt=%0d/%0d", obs_vec, stall_cycles, flush_count, exp_vec, m_stall, m_flush);
    end
  endtask

  task automatic test_reset_mid_refill();
    clear_inputs();
    dmiss = 1'b1;
    tick();
    dmiss = 1'b0;
    #2;
    arst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (mem_req !== 1'b0 || stall_back !== 1'b0 || stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_refill: got req=%b sb=%b cnt=%0d/%0d, want 0 0 0/0", mem_req, stall_back, stall_cycles, flush_count);
    end
    @(negedge clk);
    arst = 1'b0;
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf_counters();
    clear_inputs();
    load_exec = 1'b1; rd_exec = 5'd4; rs1_dec = 5'd4;
    for (int k = 0; k < 10; k++) tick();
    clear_inputs();
    #1;
    checks++;
    if (stall_cycles !== 32'd10) begin
      errors++;
      $display("FAIL perf_stall10: got %0d, want 10", stall_cycles);
    end
    dut.stall_cnt_r = 32'hFFFF_FFFE;
    m_stall = 32'hFFFF_FFFE;
    load_exec = 1'b1; rd_exec = 5'd4; rs1_dec = 5'd4;
    for (int k = 0; k < 3; k++) tick();
    clear_inputs();
    #1;
    checks++;
    if (stall_cycles !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL perf_saturate: got %h, want FFFFFFFF", stall_cycles);
    end
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rs1_dec   = 5'($urandom_range(0, 3));
      rs2_dec   = 5'($urandom_range(0, 3));
      rs1_exec  = 5'($urandom_range(0, 3));
      rs2_exec  = 5'($urandom_range(0, 3));
      rd_exec   = 5'($urandom_range(0, 3));
      rd_mem    = 5'($urandom_range(0, 3));
      rd_wb     = 5'($urandom_range(0, 3));
      we_mem    = 1'($urandom_range(0, 1));
      we_wb     = 1'($urandom_range(0, 1));
      load_exec = 1'($urandom_range(0, 1));
      pc_src    = ($urandom_range(0, 3) == 0);
      dmiss     = ($urandom_range(0, 7) == 0);
      imiss     = ($urandom_range(0, 7) == 0);
      ack       = ($urandom_range(0, 3) == 0);
      #1;
      exp_vec = expect_vec();
      checks++;
      if (obs_vec !== exp_vec || stall_cycles !== m_stall || flush_count !== m_flush) begin
        errors++;
        $display("FAIL random[%0d]: got %b cnt=%0d/%0d, want %b cnt=%0d/%0d", n, obs_vec, stall_cycles, flush_count, exp_vec, m_stall, m_flush);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_vs_load();
    test_miss();
    test_reset_mid_refill();
`ifdef HAZARD_PERF_CNT_EN
    test_perf_counters();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have the following ports; the block has one clock, and reset is asynchronous and active-high:
- i_clk  in  1  clock
- i_arst  in  1  asynchronous active-high reset
REQ-002 SHALL have these pipeline-side inputs:
- i_rs1_addr_dec, i_rs2_addr_dec  in  5  decode-stage source registers
- i_rs1_addr_exec, i_rs2_addr_exec  in  5  execute-stage source registers
- i_rd_addr_exec, i_rd_addr_mem, i_rd_addr_wb  in  5  destination registers per stage
- i_reg_we_mem, i_reg_we_wb  in  1  register-write enables
- i_pc_src_exec  in  1  branch or jump taken in execute
- i_load_instr_exec  in  1  load in execute
REQ-003 SHALL have these memory-side ports:
- i_icache_miss, i_dcache_miss  in  1  level miss indications
- i_mem_ack  in  1  refill-complete pulse
- o_mem_req  out  1  refill request
- o_mem_sel  out  1  refill target: 0 = instruction, 1 = data
REQ-004 SHALL have these control outputs:
- o_stall_fetch, o_stall_dec, o_stall_back  out  1  stall fetch / decode / exec-mem-wb registers
- o_flush_dec, o_flush_exec  out  1  flush decode / execute registers
- o_forward_rs1, o_forward_rs2  out  2  operand source: 00 regfile, 01 WB result, 10 MEM ALU result
- o_stall_cycles, o_flush_count  out  32  performance counters

Function
REQ-005 o_forward_rsN SHALL be 10 when i_reg_we_mem=1, i_rd_addr_mem!=0 and i_rd_addr_mem==i_rsN_addr_exec.
REQ-006 Otherwise o_forward_rsN SHALL be 01 when i_reg_we_wb=1, i_rd_addr_wb!=0 and i_rd_addr_wb==i_rsN_addr_exec; in all other cases 00. MEM has priority over WB.
REQ-007 A load-use hazard SHALL be defined as: i_load_instr_exec=1, i_rd_addr_exec!=0, and i_rd_addr_exec equals i_rs1_addr_dec or i_rs2_addr_dec.
REQ-008 On a load-use hazard, with the FSM in IDLE and i_pc_src_exec=0, the block SHALL assert o_stall_fetch, o_stall_dec and o_flush_exec for exactly that cycle.
REQ-009 With i_pc_src_exec=1 and the FSM in IDLE, the block SHALL assert o_flush_dec and o_flush_exec; a branch overrides a load-use stall, so o_stall_fetch and o_stall_dec stay 0.
REQ-010 Forwarding, stall and flush decisions SHALL be combinational, with zero-cycle latency.
REQ-011 The refill FSM SHALL have the states IDLE, D_WAIT and I_WAIT.
REQ-012 IDLE SHALL transition as follows:
- to D_WAIT if i_dcache_miss=1;
- else to I_WAIT if i_icache_miss=1;
- simultaneous misses: data first.
REQ-013 In D_WAIT or I_WAIT the block SHALL hold o_mem_req=1, with o_mem_sel=1 in D_WAIT and 0 in I_WAIT, and SHALL return to IDLE on the cycle i_mem_ack=1 is sampled.
REQ-014 Any state other than IDLE SHALL assert o_stall_fetch, o_stall_dec and o_stall_back, and force o_flush_dec=o_flush_exec=0.
- A pending i_pc_src_exec remains held by the stalled pipeline and is therefore applied on the first IDLE cycle.
REQ-015 The block SHALL raise o_mem_req registered: one cycle after the miss is sampled in IDLE.
REQ-016 i_mem_ack while in IDLE SHALL be ignored.
REQ-017 After returning to IDLE, a miss still asserted SHALL start a new refill on the next edge (back-to-back I then D allowed).
REQ-018 The block SHALL accept a miss changing mid-wait with no effect; the target is latched at entry.

Reset
REQ-019 While i_arst=1 the FSM SHALL be forced to IDLE asynchronously, with o_mem_req=0, o_mem_sel=0 and both counters 0.
REQ-020 Combinational outputs SHALL evaluate with the FSM in IDLE; with all inputs 0, every output is 0.
REQ-021 Reset asserted mid-refill SHALL abandon the request; o_mem_req falls within the reset cycle.

Configuration
REQ-022 The block SHALL use the macro HAZARD_PERF_CNT_EN to compile the performance counters in or out.
REQ-023 With HAZARD_PERF_CNT_EN defined, the counters SHALL behave as follows:
- o_stall_cycles increments on each clock with o_stall_fetch=1;
- o_flush_count increments on each clock with o_flush_dec=1;
- both saturate at 32'hFFFF_FFFF.
REQ-024 With HAZARD_PERF_CNT_EN undefined, both counter outputs SHALL be tied to 0 and no counter flops are generated; ports remain present.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Forwarding priority: rd_mem=rd_wb=5, both we=1, rs1_exec=5 -> o_forward_rs1=10. Clear we_mem -> 01. rd=0 case -> 00.
- Load-use: load_instr_exec=1, rd_exec=7, rs2_dec=7 -> stall_fetch=stall_dec=flush_exec=1 for one cycle, flush_dec=0.
- Branch versus load-use in the same cycle -> flush_dec=flush_exec=1, stalls 0.
- Simultaneous i/d miss -> mem_req=1 with sel=1 next cycle. Ack after 4 cycles -> IDLE, then I_WAIT with sel=0. stall_back held 1 throughout.
- i_arst pulse during D_WAIT -> mem_req=0 immediately; counters read 0.
- With HAZARD_PERF_CNT_EN and 10 stalled cycles -> o_stall_cycles=10. Preload near max -> saturates at FFFF_FFFF.
